// File: rtl/phv_queue_dispatch.sv
// Final-stage PHV dispatcher: holds one PHV and offers it to every queue named in
// its bitmap, releasing it once each targeted queue has taken exactly one copy.
module phv_queue_dispatch #(
  parameter int PHV_LEN      = 1024,
  parameter int C_NUM_QUEUES = 4,
  parameter int QUEUE_OFF    = 141,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    axis_clk,
  input  logic                    aresetn,
  input  logic [PHV_LEN-1:0]      phv_in,
  input  logic                    phv_in_valid,
  output logic                    ready_out,
  output logic [PHV_LEN-1:0]      phv_out,
  output logic [C_NUM_QUEUES-1:0] phv_out_valid,
  input  logic [C_NUM_QUEUES-1:0] phv_fifo_ready,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic [CNT_WIDTH-1:0]    mcast_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [PHV_LEN-1:0]      hold_phv;
  logic [C_NUM_QUEUES-1:0] pending;
  logic [C_NUM_QUEUES-1:0] rem;
  logic [C_NUM_QUEUES-1:0] bm;
  logic                    accept;
  logic                    bm_zero;
  logic                    bm_multi;
  logic [CNT_WIDTH-1:0]    drop_q, mcast_q;

  // Copies still owed after this cycle's grants; ready depends only on this,
  // so phv_in_valid never feeds ready_out combinationally.
  assign rem       = pending & ~phv_fifo_ready;
  assign ready_out = (rem == '0);
  assign accept    = phv_in_valid & ready_out;

  assign bm       = phv_in[QUEUE_OFF +: C_NUM_QUEUES];
  assign bm_zero  = (bm == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign bm_multi = |(bm & (bm - C_NUM_QUEUES'(1)));

  assign phv_out       = hold_phv;
  assign phv_out_valid = pending;
  assign drop_cnt      = drop_q;
  assign mcast_cnt     = mcast_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !bm_zero) state_d = HOLD;
      end
      HOLD: begin
        if (accept)            state_d = bm_zero ? IDLE : HOLD;
        else if (rem == '0)    state_d = IDLE;
        else                   state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      hold_phv <= '0;
      pending  <= '0;
      drop_q   <= '0;
      mcast_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (!bm_zero) begin
          hold_phv <= phv_in;
          pending  <= bm;
        end else begin
          pending <= '0;
          if (drop_q != '1) drop_q <= drop_q + CNT_WIDTH'(1);
        end
        if (bm_multi && (mcast_q != '1)) mcast_q <= mcast_q + CNT_WIDTH'(1);
      end else begin
        pending <= rem;
      end
    end
  end

endmodule

// File: tb/tb_phv_queue_dispatch.sv
// Directed bench for phv_queue_dispatch: unicast stream, staggered multicast,
// drops, backpressure, counter saturation and asynchronous reset mid-hold.
module tb_phv_queue_dispatch;

  localparam int PHV_LEN   = 1024;
  localparam int NQ        = 4;
  localparam int QOFF      = 141;
  localparam int CNT_WIDTH = 4;

  logic                 axis_clk = 1'b0;
  logic                 aresetn;
  logic [PHV_LEN-1:0]   phv_in;
  logic                 phv_in_valid;
  logic                 ready_out;
  logic [PHV_LEN-1:0]   phv_out;
  logic [NQ-1:0]        phv_out_valid;
  logic [NQ-1:0]        phv_fifo_ready;
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic [CNT_WIDTH-1:0] mcast_cnt;

  int total = 0;
  int bad   = 0;
  int copies [NQ];

  phv_queue_dispatch #(
    .PHV_LEN     (PHV_LEN),
    .C_NUM_QUEUES(NQ),
    .QUEUE_OFF   (QOFF),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .phv_in        (phv_in),
    .phv_in_valid  (phv_in_valid),
    .ready_out     (ready_out),
    .phv_out       (phv_out),
    .phv_out_valid (phv_out_valid),
    .phv_fifo_ready(phv_fifo_ready),
    .drop_cnt      (drop_cnt),
    .mcast_cnt     (mcast_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PHV_LEN-1:0] mk(input logic [63:0] tag, input logic [7:0] bmap);
    logic [PHV_LEN-1:0] p;
    p = '0;
    p[63:0] = tag;
    p[QOFF +: 8] = bmap;
    return p;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc;
    @(negedge axis_clk);
  endtask

  initial begin
    aresetn        = 1'b0;
    phv_in         = '0;
    phv_in_valid   = 1'b0;
    phv_fifo_ready = '0;
    #1;
    chk("rst_valid", 64'(phv_out_valid), 64'h0);
    chk("rst_ready", 64'(ready_out), 64'h1);
    chk("rst_drop",  64'(drop_cnt), 64'h0);
    chk("rst_mcast", 64'(mcast_cnt), 64'h0);
    cyc(); cyc();
    aresetn = 1'b1;

    // Unicast stream, all queues ready: one PHV per cycle.
    phv_fifo_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cyc();
      phv_in       = mk(64'(k + 1), 8'(1 << k));
      phv_in_valid = 1'b1;
      #1;
      chk("uni_ready", 64'(ready_out), 64'h1);
      chk("uni_valid", 64'(phv_out_valid), (k == 0) ? 64'h0 : 64'(1 << (k - 1)));
      if (k > 0) chk("uni_tag", phv_out[63:0], 64'(k));
    end
    cyc();
    phv_in_valid = 1'b0;
    #1;
    chk("uni_valid_last", 64'(phv_out_valid), 64'h8);
    chk("uni_tag_last", phv_out[63:0], 64'h4);
    cyc(); #1;
    chk("uni_idle", 64'(phv_out_valid), 64'h0);
    chk("uni_mcast", 64'(mcast_cnt), 64'h0);

    // Multicast 1011 with staggered readies.
    for (int i = 0; i < NQ; i++) copies[i] = 0;
    cyc();
    phv_in         = mk(64'h10, 8'b0000_1011);
    phv_in_valid   = 1'b1;
    phv_fifo_ready = 4'b0000;
    #1;
    chk("mc_accept_ready", 64'(ready_out), 64'h1);
    cyc();
    phv_in_valid   = 1'b0;
    phv_fifo_ready = 4'b0001;
    #1;
    chk("mc_v0", 64'(phv_out_valid), 64'hb);
    chk("mc_r0", 64'(ready_out), 64'h0);
    for (int i = 0; i < NQ; i++) copies[i] += int'(phv_out_valid[i] & phv_fifo_ready[i]);
    cyc();
    phv_fifo_ready = 4'b1000;
    #1;
    chk("mc_v1", 64'(phv_out_valid), 64'ha);
    chk("mc_r1", 64'(ready_out), 64'h0);
    for (int i = 0; i < NQ; i++) copies[i] += int'(phv_out_valid[i] & phv_fifo_ready[i]);
    cyc();
    phv_fifo_ready = 4'b0010;
    #1;
    chk("mc_v2", 64'(phv_out_valid), 64'h2);
    chk("mc_r2", 64'(ready_out), 64'h1);
    chk("mc_cnt", 64'(mcast_cnt), 64'h1);
    for (int i = 0; i < NQ; i++) copies[i] += int'(phv_out_valid[i] & phv_fifo_ready[i]);
    cyc();
    phv_fifo_ready = 4'b1111;
    #1;
    chk("mc_v3", 64'(phv_out_valid), 64'h0);
    chk("mc_copies_q0", 64'(copies[0]), 64'h1);
    chk("mc_copies_q1", 64'(copies[1]), 64'h1);
    chk("mc_copies_q2", 64'(copies[2]), 64'h0);
    chk("mc_copies_q3", 64'(copies[3]), 64'h1);

    // Drops: only an out-of-range bitmap bit, then an all-zero bitmap.
    cyc();
    phv_in       = mk(64'h20, 8'b0010_0000);
    phv_in_valid = 1'b1;
    #1;
    chk("drop_ready0", 64'(ready_out), 64'h1);
    cyc();
    phv_in = mk(64'h21, 8'h00);
    #1;
    chk("drop_valid0", 64'(phv_out_valid), 64'h0);
    chk("drop_cnt1", 64'(drop_cnt), 64'h1);
    chk("drop_ready1", 64'(ready_out), 64'h1);
    cyc();
    phv_in_valid = 1'b0;
    #1;
    chk("drop_valid1", 64'(phv_out_valid), 64'h0);
    chk("drop_cnt2", 64'(drop_cnt), 64'h2);
    chk("drop_hold_tag", phv_out[63:0], 64'h10);

    // Backpressure on queue 2 for 10 cycles with a waiting next PHV.
    cyc();
    phv_in         = mk(64'h30, 8'b0000_0100);
    phv_in_valid   = 1'b1;
    phv_fifo_ready = 4'b1011;
    cyc();
    phv_in = mk(64'h31, 8'b0000_0001);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      #1;
      chk("bp_valid", 64'(phv_out_valid), 64'h4);
      chk("bp_tag", phv_out[63:0], 64'h30);
      chk("bp_ready", 64'(ready_out), 64'h0);
    end
    cyc();
    phv_fifo_ready = 4'b1111;
    #1;
    chk("bp_grant_ready", 64'(ready_out), 64'h1);
    chk("bp_grant_valid", 64'(phv_out_valid), 64'h4);
    cyc();
    phv_in_valid = 1'b0;
    #1;
    chk("bp_next_valid", 64'(phv_out_valid), 64'h1);
    chk("bp_next_tag", phv_out[63:0], 64'h31);
    cyc(); #1;
    chk("bp_idle", 64'(phv_out_valid), 64'h0);

    // Saturation: 20 more drops on a 4-bit counter that already holds 2.
    cyc();
    phv_in       = mk(64'h40, 8'h00);
    phv_in_valid = 1'b1;
    for (int k = 0; k < 19; k++) cyc();
    cyc();
    phv_in_valid = 1'b0;
    #1;
    chk("sat_drop", 64'(drop_cnt), 64'hf);
    chk("sat_mcast", 64'(mcast_cnt), 64'h1);

    // Asynchronous reset while holding a 0101 multicast.
    cyc();
    phv_in         = mk(64'h50, 8'b0000_0101);
    phv_in_valid   = 1'b1;
    phv_fifo_ready = 4'b0000;
    cyc();
    phv_in_valid = 1'b0;
    #1;
    chk("rst2_pre_valid", 64'(phv_out_valid), 64'h5);
    chk("rst2_pre_mcast", 64'(mcast_cnt), 64'h2);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst2_valid", 64'(phv_out_valid), 64'h0);
    chk("rst2_ready", 64'(ready_out), 64'h1);
    chk("rst2_drop",  64'(drop_cnt), 64'h0);
    chk("rst2_mcast", 64'(mcast_cnt), 64'h0);
    chk("rst2_tag",   phv_out[63:0], 64'h0);
    cyc();
    aresetn = 1'b1;
    cyc(); #1;
    chk("rst2_after_valid", 64'(phv_out_valid), 64'h0);
    chk("rst2_after_ready", 64'(ready_out), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
